// File: rtl/csr_rmw_seq.sv
// Zicsr read-modify-write sequencer: takes one CSR instruction from decode, reads the CSR,
// writes back the modified value, and returns the old value for rd writeback.
module csr_rmw_seq #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CSR_AW  = 12,
  parameter logic [2:0]  IMM_I   = 3'd0,
  parameter logic [2:0]  IMM_CSR = 3'd5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_instr,
  input  logic [XLEN-1:0]   rs1_data,
  output logic [2:0]        imm_sel,
  input  logic [XLEN-1:0]   imm_val,
  input  logic              flush,
  output logic [CSR_AW-1:0] csr_addr,
  output logic              csr_ren,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              csr_wen,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [4:0]        resp_rd,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_err,
  output logic [1:0]        dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready is high only in IDLE; resp_* hold stable while resp_valid waits for resp_ready.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [CSR_AW-1:0] addr_q;
  logic [4:0]        rd_q;
  logic [2:0]        f3_q;
  logic              src_zero_q;
  logic [XLEN-1:0]   operand_q;
  logic [XLEN-1:0]   resp_data_q;
  logic              err_q;

  logic [2:0]        req_f3;
  logic              req_legal;
  logic [XLEN-1:0]   new_val;
  logic              write_allowed;
  logic              unused_instr;

  assign req_f3       = req_instr[14:12];
  assign req_legal    = (req_f3[1:0] != 2'b00);
  assign unused_instr = ^req_instr[6:0];

  assign imm_sel = req_instr[14] ? IMM_CSR : IMM_I;

  always_comb begin
    new_val = operand_q;
    case (f3_q[1:0])
      2'b10:   new_val = csr_rdata | operand_q;
      2'b11:   new_val = csr_rdata & ~operand_q;
      default: new_val = operand_q;
    endcase
  end

  // Set/clear with a zero source register or zimm must not cause a write side effect.
  assign write_allowed = !(f3_q[1] && src_zero_q);

  assign req_ready   = (state_q == S_IDLE);
  assign csr_ren     = (state_q == S_READ);
  assign csr_wen     = (state_q == S_WRITE) && write_allowed && !flush;
  assign csr_wdata   = (state_q == S_WRITE) ? new_val : '0;
  assign csr_addr    = (state_q == S_IDLE) ? '0 : addr_q;
  assign resp_valid  = (state_q == S_RESP);
  assign resp_rd     = rd_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = err_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rd_q        <= '0;
      f3_q        <= '0;
      src_zero_q  <= 1'b0;
      operand_q   <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && !flush) begin
            addr_q      <= req_instr[20 +: CSR_AW];
            rd_q        <= req_instr[11:7];
            f3_q        <= req_f3;
            src_zero_q  <= (req_instr[19:15] == 5'd0);
            operand_q   <= req_f3[2] ? imm_val : rs1_data;
            resp_data_q <= '0;
            err_q       <= !req_legal;
            state_q     <= req_legal ? S_READ : S_RESP;
          end
        end
        S_READ: begin
          state_q <= flush ? S_IDLE : S_WRITE;
        end
        S_WRITE: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            resp_data_q <= csr_rdata;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (flush || resp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
